serial_paralelo: RTL and testbench

- Receive-side counterpart of the paralelo_serial transmitter.
- Deserialises an MSB-first bit stream clocked at clk32_f into bytes.
- Hunts for the 0xBC comma/idle symbol and aligns to it; declares link lock after a run of aligned commas.
- In lock, presents data bytes with a valid flag; idle commas are suppressed.

---
 rtl/serial_paralelo_if.sv | 30 +++
 rtl/serial_paralelo.sv | 121 ++++++++++++
 tb/tb_serial_paralelo.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_paralelo_if.sv
// serial_paralelo_if: serial line in, byte/valid/strobe/lock out.
// master = line driver / byte consumer, slave = receiver.
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
`ifdef ALIGN_ERR_CNT_EN
  logic [7:0] align_err;

  modport master (
    output data_in,
    input  data_out, valid_out, byte_strobe, active, align_err
  );
  modport slave (
    input  data_in,
    output data_out, valid_out, byte_strobe, active, align_err
  );
`else
  modport master (
    output data_in,
    input  data_out, valid_out, byte_strobe, active
  );
  modport slave (
    input  data_in,
    output data_out, valid_out, byte_strobe, active
  );
`endif
endinterface

// File: rtl/serial_paralelo.sv
// serial_paralelo: MSB-first deserialiser with comma hunt, align, lock.
// Ports: clk32_f, reset (async high), bus.slave (data_in, data_out,
// valid_out, byte_strobe, active[, align_err with ALIGN_ERR_CNT_EN]).
module serial_paralelo #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input logic              clk32_f,
  input logic              reset,
  serial_paralelo_if.slave bus
);
  localparam logic [2:0] LC = 3'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  // Only the 7 newest bits are kept; with data_in they form the window.
  logic [6:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;
  logic [7:0] w;
  logic       bnd;
  logic       is_comma;

  assign w        = {sr_q, bus.data_in};
  assign bnd      = (bit_cnt_q == 3'd7);
  assign is_comma = (w == COMMA);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 3'd1;
          state_d     = (LC == 3'd1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        strobe_d  = bnd;
        if (bnd) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 3'd1;
            if (comma_cnt_d == LC)
              state_d = LOCKED;
          end else begin
            comma_cnt_d = 3'd0;
            state_d     = HUNT;
          end
        end
      end
      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        strobe_d  = bnd;
        if (bnd) begin
          data_d  = w;
          valid_d = !is_comma;
        end
      end
      default: state_d = HUNT;
    endcase
    active_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk32_f or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= w[6:0];
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.byte_strobe = strobe_q;
  assign bus.active      = active_q;

`ifdef ALIGN_ERR_CNT_EN
  logic [7:0] err_q;
  logic       align_fail;

  assign align_fail = (state_q == ALIGN) && (state_d == HUNT);

  always_ff @(posedge clk32_f or posedge reset) begin
    if (reset)
      err_q <= '0;
    else if (align_fail && err_q != 8'hFF)
      err_q <= err_q + 8'd1;
  end

  assign bus.align_err = err_q;
`endif
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: random and directed streams vs bit-index model.
// Compares all outputs every bit clock and around async resets.
module tb_serial_paralelo;
  localparam int LC = 4;
  localparam logic [7:0] K = 8'hBC;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  logic q[$];

  serial_paralelo_if bus ();

  serial_paralelo #(
    .COMMA     (K),
    .LOCK_COUNT(LC)
  ) dut (
    .clk32_f(clk),
    .reset  (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: bits are numbered from reset; once a comma is seen at
  // index a, every index a+8k closes a byte.
  logic [7:0] m_win;
  int         m_idx;
  int         m_anchor;
  int         m_commas;
  logic       m_locked;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_strobe;
  logic [7:0] m_err;

  task automatic mdl_reset();
    m_win    = 8'h00;
    m_idx    = 0;
    m_anchor = -1;
    m_commas = 0;
    m_locked = 1'b0;
    m_data   = 8'h00;
    m_valid  = 1'b0;
    m_strobe = 1'b0;
    m_err    = 8'h00;
  endtask

  task automatic mdl_step(input logic b);
    m_win    = {m_win[6:0], b};
    m_idx    = m_idx + 1;
    m_strobe = 1'b0;
    if (m_anchor < 0) begin
      if (m_win == K) begin
        m_anchor = m_idx;
        m_commas = 1;
        if (LC == 1) m_locked = 1'b1;
      end
    end else if ((m_idx - m_anchor) % 8 == 0) begin
      m_strobe = 1'b1;
      if (m_locked) begin
        m_data  = m_win;
        m_valid = (m_win != K);
      end else if (m_win == K) begin
        m_commas = m_commas + 1;
        if (m_commas == LC) m_locked = 1'b1;
      end else begin
        m_anchor = -1;
        m_commas = 0;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
    end
  endtask

  function automatic logic [18:0] mdl_vec();
    logic [7:0] e;
`ifdef ALIGN_ERR_CNT_EN
    e = m_err;
`else
    e = 8'h00;
`endif
    return {e, m_data, m_valid, m_strobe, m_locked};
  endfunction

  function automatic logic [18:0] dut_vec();
    logic [7:0] e;
`ifdef ALIGN_ERR_CNT_EN
    e = bus.align_err;
`else
    e = 8'h00;
`endif
    return {e, bus.data_out, bus.valid_out, bus.byte_strobe, bus.active};
  endfunction

  task automatic step(input logic b);
    bus.data_in = b;
    @(posedge clk);
    mdl_step(b);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) q.push_back(v[i]);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    mdl_reset();
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    mdl_reset();
    bus.data_in = 1'b0;
    #1;
    if (dut_vec() !== mdl_vec()) begin
      fails++;
      $display("FAIL reset_init got %h exp %h", dut_vec(), mdl_vec());
    end
    checks++;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    for (int i = 0; i < LC; i++) push_byte(K);
    push_byte(8'($urandom_range(0, 187)));
    foreach (q[i]) step(q[i]);
    #2 rst = 1'b1;
    mdl_reset();
    #1;
    if (dut_vec() !== 19'h0) begin
      fails++;
      $display("FAIL reset_async got %h exp %h", dut_vec(), 19'h0);
    end
    checks++;
    #1 rst = 1'b0;
  endtask

  task automatic test_basic_lock();
    do_reset();
    q.delete();
    for (int i = 0; i < LC; i++) push_byte(K);
    push_byte(8'h5A);
    push_byte(8'hC3);
    foreach (q[i]) begin
      step(q[i]);
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL basic_lock bit%0d got %h exp %h",
                 i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if (bus.data_out !== 8'hC3 || bus.valid_out !== 1'b1) begin
      fails++;
      $display("FAIL basic_lock_end got %h/%b exp c3/1",
               bus.data_out, bus.valid_out);
    end
    checks++;
  endtask

  task automatic test_offset();
    do_reset();
    q.delete();
    q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    for (int i = 0; i < LC; i++) push_byte(K);
    push_byte(8'hA7);
    foreach (q[i]) begin
      step(q[i]);
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL offset bit%0d got %h exp %h",
                 i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if (bus.data_out !== 8'hA7 || bus.active !== 1'b1) begin
      fails++;
      $display("FAIL offset_end got %h/%b exp a7/1",
               bus.data_out, bus.active);
    end
    checks++;
  endtask

  task automatic test_failed_align();
    do_reset();
    q.delete();
    push_byte(K);
    push_byte(K);
    push_byte(8'h11);
    for (int i = 0; i < LC; i++) push_byte(K);
    push_byte(8'h22);
    foreach (q[i]) begin
      step(q[i]);
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL failed_align bit%0d got %h exp %h",
                 i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if (bus.data_out !== 8'h22 || bus.valid_out !== 1'b1) begin
      fails++;
      $display("FAIL failed_align_end got %h/%b exp 22/1",
               bus.data_out, bus.valid_out);
    end
    checks++;
`ifdef ALIGN_ERR_CNT_EN
    if (bus.align_err !== 8'd1) begin
      fails++;
      $display("FAIL align_err got %0d exp 1", bus.align_err);
    end
    checks++;
`endif
  endtask

  task automatic test_idle_in_lock();
    q.delete();
    push_byte(8'h33);
    push_byte(K);
    push_byte(8'h44);
    foreach (q[i]) begin
      step(q[i]);
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL idle bit%0d got %h exp %h",
                 i, dut_vec(), mdl_vec());
      end
      checks++;
    end
  endtask

  task automatic test_reset_locked();
    for (int i = 0; i < 3; i++) step(1'($urandom));
    #2 rst = 1'b1;
    mdl_reset();
    #1;
    if (dut_vec() !== 19'h0) begin
      fails++;
      $display("FAIL reset_locked got %h exp %h", dut_vec(), 19'h0);
    end
    checks++;
    #1 rst = 1'b0;
    q.delete();
    for (int i = 0; i < LC; i++) push_byte(K);
    push_byte(8'h99);
    foreach (q[i]) begin
      step(q[i]);
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL relock bit%0d got %h exp %h",
                 i, dut_vec(), mdl_vec());
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_reset();
      q.delete();
      for (int j = 0; j < $urandom_range(0, 7); j++)
        q.push_back(1'($urandom));
      for (int i = 0; i < $urandom_range(1, LC + 1); i++) push_byte(K);
      for (int i = 0; i < 24; i++) begin
        if ($urandom_range(0, 3) == 0) push_byte(K);
        else push_byte(8'($urandom));
      end
      foreach (q[i]) begin
        step(q[i]);
        if (dut_vec() !== mdl_vec()) begin
          fails++;
          $display("FAIL random r%0d bit%0d got %h exp %h",
                   r, i, dut_vec(), mdl_vec());
        end
        checks++;
      end
    end
  endtask

`ifdef ALIGN_ERR_CNT_EN
  task automatic test_err_sat();
    do_reset();
    for (int n = 0; n < 260; n++) begin
      q.delete();
      push_byte(K);
      push_byte(8'h00);
      foreach (q[i]) step(q[i]);
    end
    if (bus.align_err !== 8'hFF || m_err !== 8'hFF) begin
      fails++;
      $display("FAIL err_sat got %h exp ff", bus.align_err);
    end
    checks++;
  endtask
`endif

  initial begin
    checks      = 0;
    fails       = 0;
    rst         = 1'b0;
    bus.data_in = 1'b0;
    mdl_reset();
    test_reset();
    test_basic_lock();
    test_offset();
    test_failed_align();
    test_idle_in_lock();
    test_reset_locked();
    test_random();
`ifdef ALIGN_ERR_CNT_EN
    test_err_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
